// File: rtl/pong_score_if.sv
// Signal bundle between the pong score/display block and its environment:
// point and clear requests in, scores, game status and 7-segment drive out.
interface pong_score_if;
  logic       p1_point;
  logic       p2_point;
  logic       clear;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic       winner;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output p1_point, p2_point, clear,
    input  p1_score, p2_score, game_over, winner, seg, an, dp
  );

  modport slave (
    input  p1_point, p2_point, clear,
    output p1_score, p2_score, game_over, winner, seg, an, dp
  );
endinterface

// File: rtl/pong_score.sv
// Two-player pong scoreboard: rising-edge point crediting, PLAY/OVER game FSM
// and a multiplexed 4-digit seven-segment display (p1, dash, dash, p2).
module pong_score #(
  parameter int WIN_SCORE   = 9,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  pong_score_if.slave bus
);

  localparam int          RW      = $clog2(REFRESH_DIV);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    p1_score_q, p1_score_d;
  logic [3:0]    p2_score_q, p2_score_d;
  logic          winner_q, winner_d;
  logic          p1_prev_q, p2_prev_q;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic p1_rise, p2_rise, p1_credit, p2_credit;

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Simultaneous rises cancel each other so neither player is credited.
  assign p1_rise   = bus.p1_point & ~p1_prev_q;
  assign p2_rise   = bus.p2_point & ~p2_prev_q;
  assign p1_credit = p1_rise & ~p2_rise;
  assign p2_credit = p2_rise & ~p1_rise;

  // Game state and score next-state; clear outranks any point this cycle.
  always_comb begin
    state_d    = state_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    if (bus.clear) begin
      state_d    = PLAY;
      p1_score_d = 4'd0;
      p2_score_d = 4'd0;
      winner_d   = 1'b0;
    end else if ((state_q == PLAY) && p1_credit && (p1_score_q < WIN)) begin
      p1_score_d = p1_score_q + 4'd1;
      if ((p1_score_q + 4'd1) == WIN) begin
        state_d  = OVER;
        winner_d = 1'b0;
      end else begin
        state_d  = PLAY;
      end
    end else if ((state_q == PLAY) && p2_credit && (p2_score_q < WIN)) begin
      p2_score_d = p2_score_q + 4'd1;
      if ((p2_score_q + 4'd1) == WIN) begin
        state_d  = OVER;
        winner_d = 1'b1;
      end else begin
        state_d  = PLAY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Display scan: digit index advances once per refresh period.
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == REF_MAX) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end else begin
      digit_d   = digit_q;
    end
    case (digit_q)
      2'd0:    seg_d = seg_enc(p2_score_q);
      2'd3:    seg_d = seg_enc(p1_score_q);
      default: seg_d = SEG_DASH;
    endcase
    an_d = ~(4'b0001 << digit_q);
    dp_d = ~((state_q == OVER) &&
             (((winner_q == 1'b0) && (digit_q == 2'd3)) ||
              ((winner_q == 1'b1) && (digit_q == 2'd0))));
  end

  // All state and display registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PLAY;
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      winner_q   <= 1'b0;
      p1_prev_q  <= 1'b0;
      p2_prev_q  <= 1'b0;
      refresh_q  <= '0;
      digit_q    <= 2'd0;
      seg_q      <= 7'b1000000;
      an_q       <= 4'b1110;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      p1_prev_q  <= bus.p1_point;
      p2_prev_q  <= bus.p2_point;
      refresh_q  <= refresh_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.p1_score  = p1_score_q;
  assign bus.p2_score  = p2_score_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.winner    = winner_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;

endmodule

// File: tb/tb_pong_score.sv
// Bench for pong_score: a cycle-level game/display model checked every cycle,
// directed scenarios pinned with literal expectations, and random play.
module tb_pong_score;
  localparam int WIN = 3;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic checking = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pong_score_if bus();

  pong_score #(.WIN_SCORE(WIN), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: scores as integers, game flags, cycle count since reset.
  int         m_p1, m_p2, m_cyc;
  bit         m_prev1, m_prev2, m_over, m_win;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic       m_dp;

  function automatic logic [6:0] digit_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int idx_of(input int cyc);
    return (cyc / DIV) % 4;
  endfunction

  function automatic logic [3:0] an_of(input int cyc);
    case (idx_of(cyc))
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int cyc, input int p1, input int p2);
    if (idx_of(cyc) == 3) return digit_seg(p1);
    else if (idx_of(cyc) == 0) return digit_seg(p2);
    else return 7'b0111111;
  endfunction

  function automatic logic dp_of(input int cyc, input bit over, input bit win);
    if (over && !win && idx_of(cyc) == 3) return 1'b0;
    else if (over && win && idx_of(cyc) == 0) return 1'b0;
    else return 1'b1;
  endfunction

  wire rise1 = bus.p1_point & ~m_prev1;
  wire rise2 = bus.p2_point & ~m_prev2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p1 <= 0; m_p2 <= 0; m_cyc <= 0;
      m_prev1 <= 1'b0; m_prev2 <= 1'b0; m_over <= 1'b0; m_win <= 1'b0;
      m_an <= 4'b1110; m_seg <= 7'b1000000; m_dp <= 1'b1;
    end else begin
      m_an    <= an_of(m_cyc);
      m_seg   <= seg_of(m_cyc, m_p1, m_p2);
      m_dp    <= dp_of(m_cyc, m_over, m_win);
      m_cyc   <= m_cyc + 1;
      m_prev1 <= bus.p1_point;
      m_prev2 <= bus.p2_point;
      if (bus.clear) begin
        m_p1 <= 0; m_p2 <= 0; m_over <= 1'b0; m_win <= 1'b0;
      end else if (!m_over) begin
        if (rise1 && !rise2) begin
          m_p1 <= m_p1 + 1;
          if (m_p1 + 1 == WIN) begin m_over <= 1'b1; m_win <= 1'b0; end
        end else if (rise2 && !rise1) begin
          m_p2 <= m_p2 + 1;
          if (m_p2 + 1 == WIN) begin m_over <= 1'b1; m_win <= 1'b1; end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checking) begin
      cmp("p1_score", 32'(bus.p1_score), 32'(m_p1));
      cmp("p2_score", 32'(bus.p2_score), 32'(m_p2));
      cmp("game_over", 32'(bus.game_over), 32'(m_over));
      if (m_over) cmp("winner", 32'(bus.winner), 32'(m_win));
      cmp("an", 32'(bus.an), 32'(m_an));
      cmp("seg", 32'(bus.seg), 32'(m_seg));
      cmp("dp", 32'(bus.dp), 32'(m_dp));
    end
  end

  task automatic pulse(input bit sel);
    if (sel) bus.p2_point = 1'b1; else bus.p1_point = 1'b1;
    repeat (2) @(negedge clk);
    if (sel) bus.p2_point = 1'b0; else bus.p1_point = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [3:0] an_s [16];
    logic [6:0] seg_s [16];
    logic [3:0] an_req [4];
    int t;
    an_req[0] = 4'b1110; an_req[1] = 4'b1101; an_req[2] = 4'b1011; an_req[3] = 4'b0111;
    bus.p1_point = 1'b0; bus.p2_point = 1'b0; bus.clear = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    cmp("rst_an", 32'(bus.an), 32'(4'b1110));
    cmp("rst_seg", 32'(bus.seg), 32'(7'b1000000));
    cmp("rst_dp", 32'(bus.dp), 32'd1);
    cmp("rst_p1", 32'(bus.p1_score), 32'd0);
    cmp("rst_over", 32'(bus.game_over), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    bus.p1_point = 1'b1;
    repeat (10) @(negedge clk);
    bus.p1_point = 1'b0;
    repeat (2) @(negedge clk);
    cmp("hold_p1", 32'(bus.p1_score), 32'd1);
    cmp("hold_p2", 32'(bus.p2_score), 32'd0);

    repeat (3) pulse(1'b1);
    cmp("win_p2", 32'(bus.p2_score), 32'd3);
    cmp("win_over", 32'(bus.game_over), 32'd1);
    cmp("win_winner", 32'(bus.winner), 32'd1);
    repeat (2) pulse(1'b0);
    cmp("over_p1_hold", 32'(bus.p1_score), 32'd1);

    bus.clear = 1'b1; bus.p1_point = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0; bus.p1_point = 1'b0;
    @(negedge clk);
    cmp("clr_p1", 32'(bus.p1_score), 32'd0);
    cmp("clr_p2", 32'(bus.p2_score), 32'd0);
    cmp("clr_over", 32'(bus.game_over), 32'd0);
    cmp("clr_winner", 32'(bus.winner), 32'd0);

    bus.p1_point = 1'b1; bus.p2_point = 1'b1;
    repeat (2) @(negedge clk);
    bus.p1_point = 1'b0; bus.p2_point = 1'b0;
    repeat (2) @(negedge clk);
    cmp("both_p1", 32'(bus.p1_score), 32'd0);
    cmp("both_p2", 32'(bus.p2_score), 32'd0);

    repeat (2) pulse(1'b0);
    cmp("two_p1", 32'(bus.p1_score), 32'd2);
    t = 0;
    while (bus.an === 4'b1110 && t < 20) begin @(negedge clk); t++; end
    while (bus.an !== 4'b1110 && t < 40) begin @(negedge clk); t++; end
    cmp("an_sync", 32'(bus.an), 32'(4'b1110));
    for (int i = 0; i < 16; i++) begin
      an_s[i] = bus.an; seg_s[i] = bus.seg;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) cmp("scan_an", 32'(an_s[i]), 32'(an_req[i / 4]));
    cmp("scan_seg_p1", 32'(seg_s[12]), 32'(7'b0100100));

    repeat (400) begin
      if ($urandom_range(0, 2) == 0) bus.p1_point = ~bus.p1_point;
      if ($urandom_range(0, 2) == 0) bus.p2_point = ~bus.p2_point;
      bus.clear = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    bus.p1_point = 1'b0; bus.p2_point = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    pulse(1'b0);
    t = 0;
    while (bus.an !== 4'b1011 && t < 20) begin @(negedge clk); t++; end
    cmp("pre_rst_an", 32'(bus.an), 32'(4'b1011));
    cmp("pre_rst_p1", 32'(bus.p1_score), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    cmp("async_an", 32'(bus.an), 32'(4'b1110));
    cmp("async_seg", 32'(bus.seg), 32'(7'b1000000));
    cmp("async_dp", 32'(bus.dp), 32'd1);
    cmp("async_p1", 32'(bus.p1_score), 32'd0);
    cmp("async_over", 32'(bus.game_over), 32'd0);
    bus.p1_point = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmp("held_thru_rst", 32'(bus.p1_score), 32'd1);
    bus.p1_point = 1'b0;
    repeat (4) @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
